// File: rtl/gb_fb_pkg.sv
// Shared types and constants for the Game Boy framebuffer triple-buffer scheduler.
package gb_fb_pkg;

  typedef logic [1:0] bank_t;

  localparam int unsigned FB_PIXELS = 23040;
  localparam int unsigned FB_ADDR_W = 15;

  typedef enum logic {
    WR_IDLE,
    WR_FILL
  } wr_state_t;

endpackage

// File: rtl/gb_fb_wr_addr_gen.sv
// Writer FSM: pixel counter, end-of-frame wrap detection and registered framebuffer write port.
module gb_fb_wr_addr_gen
  import gb_fb_pkg::*;
#(
  parameter int unsigned FB_PIXELS = gb_fb_pkg::FB_PIXELS,
  parameter int unsigned FB_ADDR_W = gb_fb_pkg::FB_ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 lcd_on,
  input  logic                 px_valid,
  input  logic [1:0]           px_data,
  input  bank_t                cur_bank,
  output logic                 wr_we,
  output bank_t                wr_bank,
  output logic [FB_ADDR_W-1:0] wr_addr,
  output logic [1:0]           wr_data,
  output logic                 frame_done
);

  localparam logic [FB_ADDR_W-1:0] LAST_PX = FB_ADDR_W'(FB_PIXELS - 1);

  wr_state_t            r_state;
  logic [FB_ADDR_W-1:0] r_cnt;
  logic                 r_we;
  bank_t                r_bank;
  logic [FB_ADDR_W-1:0] r_addr;
  logic [1:0]           r_data;

  logic w_write;
  logic w_last;

  // A pixel is accepted only while filling with the LCD still on in the same cycle.
  assign w_write    = (r_state == WR_FILL) && lcd_on && px_valid;
  assign w_last     = (r_cnt == LAST_PX);
  assign frame_done = w_write && w_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= WR_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_bank  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        WR_IDLE: begin
          r_cnt <= '0;
          if (lcd_on) r_state <= WR_FILL;
        end
        WR_FILL: begin
          if (!lcd_on) begin
            r_state <= WR_IDLE;
            r_cnt   <= '0;
          end else if (px_valid) begin
            r_we   <= 1'b1;
            r_bank <= cur_bank;
            r_addr <= r_cnt;
            r_data <= px_data;
            r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
          end
        end
        default: r_state <= WR_IDLE;
      endcase
    end
  end

  assign wr_we   = r_we;
  assign wr_bank = r_bank;
  assign wr_addr = r_addr;
  assign wr_data = r_data;

endmodule

// File: rtl/gb_fb_bank_sched.sv
// Triple-buffer bank scheduler: rotates writer/reader/pending bank roles so scan-out never tears.
module gb_fb_bank_sched
  import gb_fb_pkg::*;
#(
  parameter int unsigned FB_PIXELS = gb_fb_pkg::FB_PIXELS,
  parameter int unsigned FB_ADDR_W = gb_fb_pkg::FB_ADDR_W,
  parameter int unsigned DROP_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 lcd_on,
  input  logic                 px_valid,
  input  logic [1:0]           px_data,
  input  logic                 rd_vsync,
  output logic                 wr_we,
  output logic [1:0]           wr_bank,
  output logic [FB_ADDR_W-1:0] wr_addr,
  output logic [1:0]           wr_data,
  output logic [1:0]           rd_bank,
  output logic                 rd_valid,
  output logic [DROP_W-1:0]    frames_dropped
);

  bank_t             r_w;
  bank_t             r_r;
  bank_t             r_p;
  logic              r_pend;
  logic              r_rd_valid;
  logic [DROP_W-1:0] r_drop;

  logic w_frame_done;
  logic w_drop;

  gb_fb_wr_addr_gen #(
    .FB_PIXELS(FB_PIXELS),
    .FB_ADDR_W(FB_ADDR_W)
  ) u_wr (
    .clk       (clk),
    .reset_n   (reset_n),
    .lcd_on    (lcd_on),
    .px_valid  (px_valid),
    .px_data   (px_data),
    .cur_bank  (r_w),
    .wr_we     (wr_we),
    .wr_bank   (wr_bank),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_done(w_frame_done)
  );

  // A pending frame is lost whenever a newer completed frame supersedes it.
  assign w_drop = w_frame_done && r_pend;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_w        <= 2'd0;
      r_r        <= 2'd1;
      r_p        <= 2'd2;
      r_pend     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_drop     <= '0;
    end else begin
      case ({w_frame_done, rd_vsync})
        2'b10: begin
          r_w    <= r_p;
          r_p    <= r_w;
          r_pend <= 1'b1;
        end
        2'b01: begin
          if (r_pend) begin
            r_r        <= r_p;
            r_p        <= r_r;
            r_pend     <= 1'b0;
            r_rd_valid <= 1'b1;
          end
        end
        2'b11: begin
          // Freshest frame bypasses pending and goes straight to scan-out.
          r_r        <= r_w;
          r_w        <= r_r;
          r_pend     <= 1'b0;
          r_rd_valid <= 1'b1;
        end
        default: ;
      endcase
      if (w_drop && (r_drop != '1)) r_drop <= r_drop + 1'b1;
    end
  end

  assign rd_bank        = r_r;
  assign rd_valid       = r_rd_valid;
  assign frames_dropped = r_drop;

endmodule

// File: tb/tb_gb_fb_bank_sched.sv
// Directed bench: one full-size instance for the address sweep, one short-frame instance for role rotation.
module tb_gb_fb_bank_sched;

  localparam int unsigned NS = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic lcd_on = 1'b0;
  logic px_valid = 1'b0;
  logic px_valid_f = 1'b0;
  logic [1:0] px_data = '0;
  logic rd_vsync = 1'b0;

  logic        wr_we, wr_we_f;
  logic [1:0]  wr_bank, wr_bank_f, wr_data, wr_data_f, rd_bank, rd_bank_f;
  logic [14:0] wr_addr, wr_addr_f;
  logic        rd_valid, rd_valid_f;
  logic [7:0]  drops, drops_f;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gb_fb_bank_sched u_full (
    .clk(clk), .reset_n(reset_n), .lcd_on(lcd_on), .px_valid(px_valid_f),
    .px_data(px_data), .rd_vsync(rd_vsync), .wr_we(wr_we_f), .wr_bank(wr_bank_f),
    .wr_addr(wr_addr_f), .wr_data(wr_data_f), .rd_bank(rd_bank_f),
    .rd_valid(rd_valid_f), .frames_dropped(drops_f)
  );

  gb_fb_bank_sched #(.FB_PIXELS(NS), .FB_ADDR_W(15), .DROP_W(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .lcd_on(lcd_on), .px_valid(px_valid),
    .px_data(px_data), .rd_vsync(rd_vsync), .wr_we(wr_we), .wr_bank(wr_bank),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_bank(rd_bank),
    .rd_valid(rd_valid), .frames_dropped(drops)
  );

  // Stimulus helpers; all start and end right after a falling edge.
  task automatic pix(input logic [1:0] d, input logic vs);
    px_valid = 1'b1; px_data = d; rd_vsync = vs;
    @(negedge clk);
    px_valid = 1'b0; rd_vsync = 1'b0;
  endtask

  task automatic send_frame(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) pix(2'(i), 1'b0);
  endtask

  task automatic vsync();
    rd_vsync = 1'b1;
    @(negedge clk);
    rd_vsync = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; lcd_on = 1'b0; px_valid = 1'b0; px_valid_f = 1'b0; rd_vsync = 1'b0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({wr_we, wr_bank, wr_addr, wr_data} !== 20'd0) begin
      n_fail++; $display("FAIL reset_wr: got %0d/%0d/%0d/%0d want 0/0/0/0", wr_we, wr_bank, wr_addr, wr_data);
    end
    n_tests++;
    if (rd_bank !== 2'd1 || rd_valid !== 1'b0 || drops !== 8'd0) begin
      n_fail++; $display("FAIL reset_rd: got bank %0d valid %0d drops %0d want 1/0/0", rd_bank, rd_valid, drops);
    end
    n_tests++;
    if (rd_bank_f !== 2'd1 || wr_addr_f !== 15'd0 || wr_we_f !== 1'b0) begin
      n_fail++; $display("FAIL reset_full: got bank %0d addr %0d we %0d want 1/0/0", rd_bank_f, wr_addr_f, wr_we_f);
    end
  endtask

  task automatic test_full_frame();
    logic bad = 1'b0;
    logic [14:0] bad_addr = '0;
    int unsigned bad_i = 0;
    lcd_on = 1'b1;
    @(negedge clk);
    for (int unsigned i = 0; i < 23040; i++) begin
      px_valid_f = 1'b1; px_data = 2'(i);
      @(negedge clk);
      if (!bad && (wr_we_f !== 1'b1 || wr_addr_f !== 15'(i) || wr_bank_f !== 2'd0 || wr_data_f !== 2'(i))) begin
        bad = 1'b1; bad_i = i; bad_addr = wr_addr_f;
      end
    end
    px_valid_f = 1'b0;
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL full_sweep: got addr %0d want %0d on bank 0", bad_addr, bad_i);
    end
    n_tests++;
    if (rd_bank_f !== 2'd1 || rd_valid_f !== 1'b0) begin
      n_fail++; $display("FAIL full_after_frame: got bank %0d valid %0d want 1/0", rd_bank_f, rd_valid_f);
    end
    vsync();
    n_tests++;
    if (rd_bank_f !== 2'd0 || rd_valid_f !== 1'b1) begin
      n_fail++; $display("FAIL full_vsync: got bank %0d valid %0d want 0/1", rd_bank_f, rd_valid_f);
    end
    px_valid_f = 1'b1; px_data = 2'd2;
    @(negedge clk);
    px_valid_f = 1'b0;
    n_tests++;
    if (wr_bank_f !== 2'd2 || wr_addr_f !== 15'd0 || wr_we_f !== 1'b1) begin
      n_fail++; $display("FAIL full_next_px: got bank %0d addr %0d want 2/0", wr_bank_f, wr_addr_f);
    end
  endtask

  task automatic test_first_frame();
    lcd_on = 1'b1;
    @(negedge clk);
    send_frame(NS);
    n_tests++;
    if (wr_we !== 1'b1 || wr_addr !== 15'(NS - 1) || wr_bank !== 2'd0 || wr_data !== 2'd3) begin
      n_fail++; $display("FAIL last_px: got we %0d addr %0d bank %0d data %0d want 1/%0d/0/3", wr_we, wr_addr, wr_bank, wr_data, NS - 1);
    end
    n_tests++;
    if (rd_bank !== 2'd1 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL no_vsync_yet: got bank %0d valid %0d want 1/0", rd_bank, rd_valid);
    end
    pix(2'd1, 1'b0);
    n_tests++;
    if (wr_bank !== 2'd2 || wr_addr !== 15'd0) begin
      n_fail++; $display("FAIL new_w: got bank %0d addr %0d want 2/0", wr_bank, wr_addr);
    end
  endtask

  task automatic test_vsync();
    vsync();
    n_tests++;
    if (rd_bank !== 2'd0 || rd_valid !== 1'b1) begin
      n_fail++; $display("FAIL vsync_swap: got bank %0d valid %0d want 0/1", rd_bank, rd_valid);
    end
    vsync();
    n_tests++;
    if (rd_bank !== 2'd0 || rd_valid !== 1'b1) begin
      n_fail++; $display("FAIL vsync_repeat: got bank %0d valid %0d want 0/1", rd_bank, rd_valid);
    end
  endtask

  task automatic test_drop();
    send_frame(NS - 1);
    pix(2'd0, 1'b0);
    n_tests++;
    if (wr_bank !== 2'd1 || wr_addr !== 15'd0) begin
      n_fail++; $display("FAIL drop_w: got bank %0d addr %0d want 1/0", wr_bank, wr_addr);
    end
    send_frame(NS - 1);
    n_tests++;
    if (drops !== 8'd1) begin
      n_fail++; $display("FAIL drop_count: got %0d want 1", drops);
    end
    vsync();
    n_tests++;
    if (rd_bank !== 2'd1) begin
      n_fail++; $display("FAIL drop_newest: got bank %0d want 1", rd_bank);
    end
  endtask

  task automatic test_same_cycle();
    send_frame(NS);
    send_frame(NS - 1);
    pix(2'd3, 1'b1);
    n_tests++;
    if (wr_bank !== 2'd0 || wr_addr !== 15'(NS - 1)) begin
      n_fail++; $display("FAIL same_last_px: got bank %0d addr %0d want 0/%0d", wr_bank, wr_addr, NS - 1);
    end
    n_tests++;
    if (rd_bank !== 2'd0 || rd_valid !== 1'b1 || drops !== 8'd2) begin
      n_fail++; $display("FAIL same_bypass: got bank %0d valid %0d drops %0d want 0/1/2", rd_bank, rd_valid, drops);
    end
    vsync();
    n_tests++;
    if (rd_bank !== 2'd0) begin
      n_fail++; $display("FAIL same_pend_clr: got bank %0d want 0", rd_bank);
    end
    pix(2'd1, 1'b0);
    n_tests++;
    if (wr_bank !== 2'd1 || wr_addr !== 15'd0) begin
      n_fail++; $display("FAIL same_new_w: got bank %0d addr %0d want 1/0", wr_bank, wr_addr);
    end
  endtask

  task automatic test_lcd_off();
    send_frame(5);
    lcd_on = 1'b0; px_valid = 1'b1;
    @(negedge clk);
    px_valid = 1'b0;
    n_tests++;
    if (wr_we !== 1'b0) begin
      n_fail++; $display("FAIL lcd_off_ignore: got we %0d want 0", wr_we);
    end
    @(negedge clk);
    lcd_on = 1'b1;
    @(negedge clk);
    pix(2'd2, 1'b0);
    n_tests++;
    if (wr_we !== 1'b1 || wr_addr !== 15'd0 || wr_bank !== 2'd1) begin
      n_fail++; $display("FAIL lcd_restart: got we %0d addr %0d bank %0d want 1/0/1", wr_we, wr_addr, wr_bank);
    end
    n_tests++;
    if (rd_bank !== 2'd0 || drops !== 8'd2) begin
      n_fail++; $display("FAIL lcd_roles: got bank %0d drops %0d want 0/2", rd_bank, drops);
    end
  endtask

  task automatic test_saturate();
    send_frame(NS - 1);
    n_tests++;
    if (drops !== 8'd2) begin
      n_fail++; $display("FAIL sat_first: got %0d want 2", drops);
    end
    for (int unsigned k = 0; k < 252; k++) send_frame(NS);
    n_tests++;
    if (drops !== 8'd254) begin
      n_fail++; $display("FAIL sat_254: got %0d want 254", drops);
    end
    send_frame(NS);
    n_tests++;
    if (drops !== 8'd255) begin
      n_fail++; $display("FAIL sat_255: got %0d want 255", drops);
    end
    send_frame(NS);
    send_frame(NS);
    n_tests++;
    if (drops !== 8'd255) begin
      n_fail++; $display("FAIL sat_hold: got %0d want 255", drops);
    end
  endtask

  task automatic test_async_reset();
    vsync();
    send_frame(5);
    n_tests++;
    if (wr_addr === 15'd0 || rd_valid !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: got addr %0d valid %0d want nonzero/1", wr_addr, rd_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({wr_we, wr_bank, wr_addr, wr_data} !== 20'd0 || rd_bank !== 2'd1 || rd_valid !== 1'b0 || drops !== 8'd0) begin
      n_fail++; $display("FAIL async_reset: got we %0d bank %0d addr %0d rd %0d valid %0d drops %0d want 0/0/0/1/0/0",
                         wr_we, wr_bank, wr_addr, rd_bank, rd_valid, drops);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    do_reset();
    test_first_frame();
    test_vsync();
    test_drop();
    test_same_cycle();
    test_lcd_off();
    test_saturate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
